// File: rtl/dm_reader_pkg.sv
// Shared definitions for the data-memory result reader: FSM state encodings
// and default data/address widths.
package dm_reader_pkg;

  localparam int DEFAULT_DW = 8;
  localparam int DEFAULT_AW = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_EMIT = 3'd3;
  localparam logic [2:0] ST_SUM  = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;

endpackage

// File: rtl/xor_accum.sv
// Running XOR of data words; clear wins over enable. Only instantiated by the
// reader when DUMP_CHECKSUM_EN is defined.
module xor_accum #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] sum_out
);

  logic [DW-1:0] sum_q;
  logic [DW-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (enable) begin
      sum_d = sum_q ^ data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_out = sum_q;

endmodule

// File: rtl/dm_result_reader.sv
// Dumps COUNT words from data memory starting at BASE onto a valid/ready
// stream. Optional trailing XOR checksum word when DUMP_CHECKSUM_EN is defined.
//
// Output handshake: OutData/OutLast are meaningful only while OutValid is high;
// once OutValid rises it stays high with OutData stable until a rising edge
// sees OutValid and OutReady both high (one transfer).
module dm_result_reader
  import dm_reader_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int AW    = DEFAULT_AW,
  parameter int BASE  = 4,
  parameter int COUNT = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic [AW-1:0] MemAddr,
  input  logic [DW-1:0] MemRdData,
  output logic [DW-1:0] OutData,
  output logic          OutValid,
  input  logic          OutReady,
  output logic          OutLast,
  output logic          Busy,
  output logic          Done,
  output logic [2:0]    dbg_state
);

  localparam logic [AW-1:0] BASE_A   = AW'(BASE);
  localparam int            LAST_INT = (COUNT > 0) ? COUNT - 1 : 0;
  localparam logic [AW-1:0] LAST_IDX = AW'(LAST_INT);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          xfer;

  assign xfer = out_valid_q & OutReady;

`ifdef DUMP_CHECKSUM_EN
  logic [DW-1:0] acc_sum;

  // Cleared while idle so each dump starts from zero; folds in every captured word.
  xor_accum #(.DW(DW)) u_xor_accum (
    .clk     (Clk),
    .rst     (Reset),
    .clear   (state_q == ST_IDLE),
    .enable  (state_q == ST_WAIT),
    .data_in (MemRdData),
    .sum_out (acc_sum)
  );
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mem_addr_d  = mem_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          idx_d = '0;
          if (COUNT == 0) begin
`ifdef DUMP_CHECKSUM_EN
            // Empty dump still emits the (zero) checksum as its only word.
            state_d     = ST_SUM;
            out_data_d  = '0;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
`else
            state_d = ST_FIN;
`endif
          end else begin
            state_d    = ST_ADDR;
            mem_addr_d = BASE_A;
          end
        end
      end
      ST_ADDR: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d     = ST_EMIT;
        out_data_d  = MemRdData;
        out_valid_d = 1'b1;
`ifdef DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (idx_q == LAST_IDX);
`endif
      end
      ST_EMIT: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (idx_q != LAST_IDX) begin
            idx_d      = idx_q + 1'b1;
            mem_addr_d = BASE_A + idx_q + 1'b1;
            state_d    = ST_ADDR;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            state_d     = ST_SUM;
            out_data_d  = acc_sum;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
`else
            state_d = ST_FIN;
`endif
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_SUM: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_FIN;
        end
      end
`endif
      ST_FIN: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      mem_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mem_addr_q  <= mem_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign MemAddr   = mem_addr_q;
  assign OutData   = out_data_q;
  assign OutValid  = out_valid_q;
  assign OutLast   = out_last_q;
  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_FIN);
  assign dbg_state = state_q;

endmodule
